// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder and the core's data port.
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StWait   = 2'd1,
      StAccess = 2'd2,
      StResp   = 2'd3
   } state_e;

   localparam logic [6:0]  OpcLw = 7'b0000011;
   localparam logic [6:0]  OpcSw = 7'b0100011;

   localparam logic [31:0] DataBaseDefault = 32'h1001_0000;

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM; read data registers the addressed word every cycle.
module data_mem_array #(
   parameter int unsigned ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] idx,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [31:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Slow data-memory responder: captures a strobe edge, waits WAIT_CYCLES, accesses the RAM,
// then pulses dReady with registered dReadData/dError.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter logic [31:0] DATA_BASE   = DataBaseDefault,
   parameter int unsigned ADDR_BITS   = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] dAddress,
   input  logic [31:0] dWriteData,
   output logic [31:0] dReadData,
   output logic        dReady,
   output logic        dError,
   output logic        busy
);

   localparam logic [3:0] WaitLoad = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        mem_read_q, mem_write_q;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        error_q, error_d;
   logic        busy_q, busy_d;

   logic        rise_rd, rise_wr;
   logic [29:0] offs_w;
   logic        acc_err;
   logic        ram_we;
   logic [31:0] ram_rdata;

   assign rise_rd = MemRead & ~mem_read_q;
   assign rise_wr = MemWrite & ~mem_write_q;

   // Decode from the next-state address so the synchronous RAM read lines up with ACCESS.
   assign offs_w  = addr_d[31:2] - DATA_BASE[31:2];
   assign acc_err = (addr_d[1:0] != 2'b00) || (offs_w[29:ADDR_BITS] != '0) || (rd_q && wr_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      error_d = error_q;
      ram_we  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rise_rd || rise_wr) begin
               addr_d  = dAddress;
               wdata_d = dWriteData;
               rd_d    = rise_rd;
               wr_d    = rise_wr;
               if (WAIT_CYCLES == 0) begin
                  state_d = StAccess;
               end else begin
                  state_d = StWait;
                  cnt_d   = WaitLoad;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StAccess;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StAccess: begin
            state_d = StResp;
            ready_d = 1'b1;
            error_d = acc_err;
            ram_we  = wr_q && !acc_err;
            if (acc_err) begin
               rdata_d = 32'd0;
            end else if (rd_q) begin
               rdata_d = ram_rdata;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         rdata_q     <= 32'd0;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_read_q  <= MemRead;
         mem_write_q <= MemWrite;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
         busy_q      <= busy_d;
      end
   end

   data_mem_array #(
      .ADDR_BITS (ADDR_BITS)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .idx   (offs_w[ADDR_BITS-1:0]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   assign dReadData = rdata_q;
   assign dReady    = ready_q;
   assign dError    = error_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder at WAIT_CYCLES of 2, 0 and 15.
module tb_data_mem_responder;

   localparam logic [31:0] Base = 32'h1001_0000;
   localparam int          Words = 1024;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        mr [3];
   logic        mw [3];
   logic [31:0] ad [3];
   logic [31:0] wd [3];

   logic [31:0] rd0, rd1, rd2;
   logic        rdy0, rdy1, rdy2, err0, err1, err2, bsy0, bsy1, bsy2;

   data_mem_responder #(.DATA_BASE(Base), .ADDR_BITS(10), .WAIT_CYCLES(2)) u_dut0 (
      .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .dAddress(ad[0]),
      .dWriteData(wd[0]), .dReadData(rd0), .dReady(rdy0), .dError(err0), .busy(bsy0));
   data_mem_responder #(.DATA_BASE(Base), .ADDR_BITS(10), .WAIT_CYCLES(0)) u_dut1 (
      .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .dAddress(ad[1]),
      .dWriteData(wd[1]), .dReadData(rd1), .dReady(rdy1), .dError(err1), .busy(bsy1));
   data_mem_responder #(.DATA_BASE(Base), .ADDR_BITS(10), .WAIT_CYCLES(15)) u_dut2 (
      .clk(clk), .rst(rst), .MemRead(mr[2]), .MemWrite(mw[2]), .dAddress(ad[2]),
      .dWriteData(wd[2]), .dReadData(rd2), .dReady(rdy2), .dError(err2), .busy(bsy2));

   int          checks   = 0;
   int          failures = 0;
   int          wcyc [3] = '{2, 0, 15};
   logic [31:0] mem_m [int];
   logic [31:0] last_rd [3];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic sample(input int i, output logic [31:0] d, output logic r, output logic e,
                         output logic b);
      case (i)
         0:       begin d = rd0; r = rdy0; e = err0; b = bsy0; end
         1:       begin d = rd1; r = rdy1; e = err1; b = bsy1; end
         default: begin d = rd2; r = rdy2; e = err2; b = bsy2; end
      endcase
   endtask

   // Called at a negedge; returns at the negedge after the RESP cycle, ready for the next request.
   task automatic xact(input int i, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit chg_addr, input bit hold);
      int          wc = wcyc[i];
      longint      off = longint'(a) - longint'(Base);
      bit          exp_err;
      int          key;
      logic [31:0] o_d;
      logic        o_r, o_e, o_b;
      exp_err = (a[1:0] != 2'b00) || (off < 0) || (off >= 4 * Words) || (r && w);
      key     = exp_err ? 0 : i * 4096 + int'(off / 4);
      mr[i] = r; mw[i] = w; ad[i] = a; wd[i] = d;
      for (int n = 1; n <= wc + 2; n++) begin
         @(negedge clk);
         if (n == 1 && chg_addr) begin
            ad[i] = a + 32'd4;
            wd[i] = ~d;
         end
         sample(i, o_d, o_r, o_e, o_b);
         chk($sformatf("busy[%0d] n=%0d", i, n), {31'd0, o_b}, 32'd1);
         chk($sformatf("ready[%0d] n=%0d", i, n), {31'd0, o_r}, {31'd0, n == wc + 2});
         if (n == wc + 2) begin
            chk($sformatf("error[%0d] a=%h", i, a), {31'd0, o_e}, {31'd0, exp_err});
            if (exp_err) begin
               last_rd[i] = 32'd0;
               chk($sformatf("rdata_err[%0d] a=%h", i, a), o_d, last_rd[i]);
            end else if (r) begin
               if (mem_m.exists(key)) begin
                  last_rd[i] = mem_m[key];
                  chk($sformatf("rdata[%0d] a=%h", i, a), o_d, last_rd[i]);
               end else begin
                  last_rd[i] = o_d;
               end
            end else begin
               chk($sformatf("rdata_hold[%0d] a=%h", i, a), o_d, last_rd[i]);
               mem_m[key] = d;
            end
            if (!hold) begin
               mr[i] = 1'b0;
               mw[i] = 1'b0;
            end
         end
      end
      @(negedge clk);
      sample(i, o_d, o_r, o_e, o_b);
      chk($sformatf("ready_done[%0d]", i), {31'd0, o_r}, 32'd0);
      chk($sformatf("busy_done[%0d]", i), {31'd0, o_b}, 32'd0);
   endtask

   logic [31:0] o_d;
   logic        o_r, o_e, o_b;
   int          kind;
   bit          rr;
   logic [31:0] a;

   initial begin
      for (int i = 0; i < 3; i++) begin
         mr[i] = 1'b0; mw[i] = 1'b0; ad[i] = '0; wd[i] = '0; last_rd[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         sample(i, o_d, o_r, o_e, o_b);
         chk($sformatf("reset_rdata[%0d]", i), o_d, 32'd0);
         chk($sformatf("reset_flags[%0d]", i), {29'd0, o_r, o_e, o_b}, 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);

      // Known contents, then a write aborted by reset mid-WAIT.
      xact(0, 0, 1, Base, 32'hA5A5_A5A5, 0, 0);
      mw[0] = 1'b1; ad[0] = Base; wd[0] = 32'hDEAD_BEEF;
      @(negedge clk);
      @(negedge clk);
      chk("busy_before_abort", {31'd0, bsy0}, 32'd1);
      rst = 1'b0;
      #1;
      chk("abort_busy", {31'd0, bsy0}, 32'd0);
      mw[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) last_rd[i] = 32'd0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk("abort_no_ready", {31'd0, rdy0}, 32'd0);
      end
      xact(0, 1, 0, Base, 32'd0, 0, 0);

      // Basic write/read.
      xact(0, 0, 1, Base + 32'h4, 32'h1234_5678, 0, 0);
      xact(0, 1, 0, Base + 32'h4, 32'd0, 0, 0);

      // Latency extremes.
      xact(1, 0, 1, Base + 32'h8, 32'hCAFE_0001, 0, 0);
      xact(1, 1, 0, Base + 32'h8, 32'd0, 0, 0);
      xact(2, 0, 1, Base + 32'hC, 32'hCAFE_0002, 0, 0);
      xact(2, 1, 0, Base + 32'hC, 32'd0, 0, 0);

      // Errors and the top boundary.
      xact(0, 1, 0, Base + 32'h2, 32'd0, 0, 0);
      xact(0, 0, 1, Base + 32'h1000, 32'h0BAD_0BAD, 0, 0);
      xact(0, 1, 0, Base, 32'd0, 0, 0);
      xact(0, 1, 0, Base - 32'h4, 32'd0, 0, 0);
      xact(0, 0, 1, Base + 32'hFFC, 32'h7777_1111, 0, 0);
      xact(0, 1, 0, Base + 32'hFFC, 32'd0, 0, 0);

      // Held strobe yields a single response.
      xact(0, 1, 0, Base + 32'h4, 32'd0, 0, 1);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk("held_no_retrigger", {31'd0, rdy0}, 32'd0);
      end
      mr[0] = 1'b0;
      @(negedge clk);

      // Conflicting strobes, then proof that nothing was written.
      xact(0, 1, 1, Base + 32'h4, 32'h5555_AAAA, 0, 0);
      xact(0, 1, 0, Base + 32'h4, 32'd0, 0, 0);

      // Inputs changed after capture are ignored.
      xact(0, 0, 1, Base + 32'h20, 32'h2020_2020, 1, 0);
      xact(0, 1, 0, Base + 32'h20, 32'd0, 1, 0);

      // Back-to-back SW/LW at minimum spacing.
      for (int k = 0; k < 6; k++) begin
         xact(0, 0, 1, Base + 32'h10, $urandom, 0, 0);
         xact(0, 1, 0, Base + 32'h10, 32'd0, 0, 0);
      end

      // Random mix over a small window plus error cases.
      for (int k = 0; k < 40; k++) begin
         kind = int'($urandom_range(0, 9));
         rr   = 1'($urandom_range(0, 1));
         case (kind)
            0:       a = Base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            1:       a = Base + 32'h1000 + 32'(4 * $urandom_range(0, 3));
            2:       a = Base - 32'(4 * $urandom_range(1, 3));
            default: a = Base + 32'(4 * $urandom_range(0, 15));
         endcase
         if (kind == 3) xact(0, 1, 1, a, $urandom, 0, 0);
         else           xact(0, rr, !rr, a, $urandom, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
